// File: rtl/mux8_rr_scheduler.sv
// mux8_rr_scheduler
//   Round-robin scheduler that time-shares one 8:1 bit-select datapath among
//   8 requesters. Each grant lasts at most BURST_MAX consecutive cycles. The
//   block drives the mux select and a one-hot grant, and registers the
//   selected data bit onto a single output channel with a valid flag.
//
// Ports
//   clk        in   1  clock, all state updates on posedge
//   rst_n      in   1  synchronous active-low reset
//   req        in   8  per-requester request
//   datain     in   8  per-requester data bit
//   sel        out  3  index of current or last grant (held while idle)
//   gnt        out  8  one-hot grant, zero when idle
//   dataout    out  1  registered datain[sel]
//   out_valid  out  1  dataout carries a granted, requested bit
//
// Parameters
//   BURST_MAX  maximum consecutive granted cycles per requester (1..2**CNT_W-1)
//   CNT_W      burst counter width

module mux8_rr_scheduler #(
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] datain,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       dataout,
  output logic       out_valid
);

  localparam int unsigned N     = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Registered state
  state_e             state_q;
  logic [SEL_W-1:0]   ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SEL_W-1:0]   sel_q;
  logic [N-1:0]       gnt_q;
  logic               dataout_q;
  logic               out_valid_q;

  // Combinational helpers
  logic [SEL_W-1:0]   ptr_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               release_c;
  logic [SEL_W-1:0]   arb_base;
  logic [SEL_W-1:0]   arb_cand;
  logic [SEL_W-1:0]   arb_idx;
  logic               arb_found;
  logic [N-1:0]       arb_onehot;

  // Pointer after a release: the slot just past the releasing requester, wrapping 7->0.
  assign ptr_d = sel_q + SEL_W'(1);

  // Burst counter increment, modulo its width.
  assign cnt_d = cnt_q + CNT_W'(1);

  // A grant ends when its requester drops or its burst budget is spent.
  assign release_c = !req[sel_q] || (cnt_q == CNT_W'(BURST_MAX));

  // When releasing, search from the updated pointer in the same edge so the
  // releasing requester is considered last and no idle bubble is inserted.
  assign arb_base = (state_q == GRANT) ? ptr_d : ptr_q;

  // Round-robin search: first set request at arb_base, arb_base+1, ... (mod 8).
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_cand  = '0;
    for (int k = 0; k < int'(N); k++) begin
      arb_cand = arb_base + SEL_W'(k);
      if (!arb_found && req[arb_cand]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand;
      end
    end
  end

  assign arb_onehot = N'(1) << arb_idx;

  // Scheduler FSM and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      sel_q       <= '0;
      gnt_q       <= '0;
      dataout_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // Datapath: one-cycle registered view of the selected lane.
      dataout_q   <= datain[sel_q];
      out_valid_q <= (state_q == GRANT) && req[sel_q];

      case (state_q)
        IDLE: begin
          if (arb_found) begin
            state_q <= GRANT;
            gnt_q   <= arb_onehot;
            sel_q   <= arb_idx;
            cnt_q   <= CNT_W'(1);
          end
        end

        GRANT: begin
          if (release_c) begin
            ptr_q <= ptr_d;
            if (arb_found) begin
              gnt_q <= arb_onehot;
              sel_q <= arb_idx;
              cnt_q <= CNT_W'(1);
            end else begin
              // sel keeps its last value while idle.
              state_q <= IDLE;
              gnt_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign dataout   = dataout_q;
  assign out_valid = out_valid_q;

  // Structural invariants of the grant state.
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt_q));

  a_gnt_iff_grant : assert property (@(posedge clk) disable iff (!rst_n)
    ((gnt_q != '0) == (state_q == GRANT)));

  a_gnt_matches_sel : assert property (@(posedge clk) disable iff (!rst_n)
    ((gnt_q != '0) |-> gnt_q[sel_q]));

  a_cnt_bounded : assert property (@(posedge clk) disable iff (!rst_n)
    (cnt_q <= CNT_W'(BURST_MAX)));

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// tb_mux8_rr_scheduler
//   Directed bench for the round-robin 8:1 scheduler: reset, full load,
//   lone requester, early drop, idle hold, pointer wrap and reset mid-burst.

module tb_mux8_rr_scheduler;

  localparam int unsigned BURST_MAX = 4;
  localparam int unsigned CNT_W     = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] datain;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       dataout;
  logic       out_valid;

  int checks = 0;
  int errors = 0;

  mux8_rr_scheduler #(
    .BURST_MAX (BURST_MAX),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .datain    (datain),
    .sel       (sel),
    .gnt       (gnt),
    .dataout   (dataout),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Two reset cycles with the given request, then the first active edge.
  task automatic reset_dut(input logic [7:0] r);
    rst_n = 1'b0;
    req   = r;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    logic [2:0] exp_sel;
    logic       exp_dout;
    int         hits [8];

    rst_n  = 1'b0;
    req    = 8'hFF;
    datain = 8'h00;
    exp_dout = 1'b0;
    @(negedge clk);

    // Reset with all requesting
    step();
    step();
    check_eq("rst_gnt",   32'(gnt),       32'h00);
    check_eq("rst_sel",   32'(sel),       32'h0);
    check_eq("rst_valid", 32'(out_valid), 32'h0);
    check_eq("rst_dout",  32'(dataout),   32'h0);
    check_eq("rst_ptr",   32'(dut.ptr_q), 32'h0);
    check_eq("rst_cnt",   32'(dut.cnt_q), 32'h0);
    rst_n = 1'b1;
    step();
    check_eq("first_gnt", 32'(gnt), 32'h01);

    // Full load: 4 cycles per index, 0..7, no gap in out_valid
    for (int i = 0; i < 8; i++) hits[i] = 0;
    for (int t = 0; t < 32; t++) begin
      exp_sel = 3'(t / 4);
      check_eq($sformatf("full_sel t%0d", t), 32'(sel),       32'(exp_sel));
      check_eq($sformatf("full_gnt t%0d", t), 32'(gnt),       32'(8'(1) << exp_sel));
      check_eq($sformatf("full_cnt t%0d", t), 32'(dut.cnt_q), 32'((t % 4) + 1));
      if (t >= 1) begin
        check_eq($sformatf("full_valid t%0d", t), 32'(out_valid), 32'h1);
        check_eq($sformatf("full_dout t%0d", t),  32'(dataout),   32'(exp_dout));
      end
      for (int i = 0; i < 8; i++) if (gnt[i]) hits[i]++;
      datain   = 8'(t * 37 + 11);
      exp_dout = datain[exp_sel];
      step();
    end
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("fair_hits r%0d", i), 32'(hits[i]), 32'd4);
    check_eq("full_wrap_sel", 32'(sel), 32'h0);
    check_eq("full_wrap_gnt", 32'(gnt), 32'h01);

    // Lone requester 3: regranted back-to-back, cnt 1..4 repeating
    datain = 8'h00;
    reset_dut(8'h08);
    for (int t = 0; t < 12; t++) begin
      check_eq($sformatf("lone_gnt t%0d", t), 32'(gnt),       32'h08);
      check_eq($sformatf("lone_sel t%0d", t), 32'(sel),       32'h3);
      check_eq($sformatf("lone_cnt t%0d", t), 32'(dut.cnt_q), 32'((t % 4) + 1));
      check_eq($sformatf("lone_valid t%0d", t), 32'(out_valid), (t >= 1) ? 32'h1 : 32'h0);
      if (t >= 1)
        check_eq($sformatf("lone_dout t%0d", t), 32'(dataout), 32'(exp_dout));
      datain   = 8'(t * 73 + 5);
      exp_dout = datain[3];
      step();
    end

    // Early drop: req 0 falls after 2 granted cycles, grant moves to 2 at same edge
    datain = 8'hFF;
    reset_dut(8'h05);
    check_eq("drop_gnt0", 32'(gnt), 32'h01);
    step();
    check_eq("drop_cnt1", 32'(dut.cnt_q), 32'h2);
    check_eq("drop_valid1", 32'(out_valid), 32'h1);
    req = 8'h04;
    step();
    check_eq("drop_gnt2",   32'(gnt),       32'h04);
    check_eq("drop_sel2",   32'(sel),       32'h2);
    check_eq("drop_valid2", 32'(out_valid), 32'h0);
    check_eq("drop_ptr",    32'(dut.ptr_q), 32'h1);
    check_eq("drop_cnt2",   32'(dut.cnt_q), 32'h1);
    step();
    check_eq("drop_valid3", 32'(out_valid), 32'h1);

    // All requests drop: go idle, sel held, then re-arbitrate from ptr 3
    req = 8'h00;
    step();
    check_eq("idle_gnt",   32'(gnt),       32'h00);
    check_eq("idle_sel",   32'(sel),       32'h2);
    check_eq("idle_valid", 32'(out_valid), 32'h0);
    check_eq("idle_ptr",   32'(dut.ptr_q), 32'h3);
    step();
    check_eq("idle_sel_hold", 32'(sel), 32'h2);
    check_eq("idle_gnt_hold", 32'(gnt), 32'h00);
    req = 8'h01;
    step();
    check_eq("idle_regrant_gnt", 32'(gnt), 32'h01);
    check_eq("idle_regrant_sel", 32'(sel), 32'h0);

    // Wrap: grant on 7 finishes with 0 pending -> 0, then back to 7
    reset_dut(8'h80);
    check_eq("wrap_gnt7", 32'(gnt), 32'h80);
    req = 8'h81;
    step();
    step();
    step();
    check_eq("wrap_cnt4", 32'(dut.cnt_q), 32'h4);
    step();
    check_eq("wrap_gnt0",  32'(gnt),       32'h01);
    check_eq("wrap_ptr0",  32'(dut.ptr_q), 32'h0);
    check_eq("wrap_valid", 32'(out_valid), 32'h1);
    step();
    step();
    step();
    check_eq("wrap_gnt0_last", 32'(gnt), 32'h01);
    step();
    check_eq("wrap_gnt7_again", 32'(gnt),       32'h80);
    check_eq("wrap_ptr1",       32'(dut.ptr_q), 32'h1);

    // Reset mid-burst at cnt=2 of index 5
    reset_dut(8'hFF);
    for (int t = 0; t < 21; t++) step();
    check_eq("mid_sel5", 32'(sel),       32'h5);
    check_eq("mid_cnt2", 32'(dut.cnt_q), 32'h2);
    rst_n = 1'b0;
    step();
    check_eq("mid_rst_gnt",   32'(gnt),       32'h00);
    check_eq("mid_rst_valid", 32'(out_valid), 32'h0);
    check_eq("mid_rst_ptr",   32'(dut.ptr_q), 32'h0);
    check_eq("mid_rst_sel",   32'(sel),       32'h0);
    rst_n = 1'b1;
    step();
    check_eq("mid_first_gnt", 32'(gnt), 32'h01);
    check_eq("mid_first_sel", 32'(sel), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
